// File: rtl/fma_pkg.sv
// Shared widths and types for the FMA normalization stage.
// SIG_WIDTH    : stored fraction width (significand out is SIG_WIDTH+1 bits)
// EXP_WIDTH    : biased exponent width
// ADDER_WIDTH  : width of the end-around-carry adder sum
// MAG_WIDTH    : magnitude width (adder sum plus carry-out)
// LZC_WIDTH    : width of a leading-zero count over MAG_WIDTH bits (0..MAG_WIDTH)
// EXP_T        : width of the signed internal exponent
package fma_pkg;

    localparam int unsigned SIG_WIDTH   = 23;
    localparam int unsigned EXP_WIDTH   = 8;
    localparam int unsigned ADDER_WIDTH = 50;
    localparam int unsigned MAG_WIDTH   = ADDER_WIDTH + 1;
    localparam int unsigned LZC_WIDTH   = $clog2(MAG_WIDTH + 1);
    localparam int unsigned EXP_T       = EXP_WIDTH + 2;
    // Bits below guard and round that collapse into sticky.
    localparam int unsigned REST_WIDTH  = MAG_WIDTH - (SIG_WIDTH + 1) - 2;

    typedef logic signed [EXP_T-1:0] exp_t;

    // Stage-1 payload: recovered magnitude and its bookkeeping.
    typedef struct packed {
        logic [MAG_WIDTH-1:0] mag;
        logic [LZC_WIDTH-1:0] lzc;
        logic                 sign;
        logic                 sticky;
        logic                 zero;
        exp_t                 exp_ref;  // exponent of magnitude bit MAG_WIDTH-1
    } s1_t;

    // Stage-2 payload: what the rounder sees.
    typedef struct packed {
        logic [SIG_WIDTH:0] sig;
        logic               guard;
        logic               round;
        logic               sticky;
        logic               sign;
        exp_t               expo;
        logic               zero;
        logic               uflow;
    } s2_t;

endpackage

// File: rtl/fma_norm_stage_if.sv
// Handshake and data bundle between the EAC adder, the normalizer and the rounder.
// master : upstream/downstream environment (drives in_* and out_ready)
// slave  : the normalizer (drives in_ready and all out_* results)
interface fma_norm_stage_if;
    import fma_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [ADDER_WIDTH-1:0] sum_in;
    logic                   cout_in;
    logic                   eff_op_in;
    logic                   sticky_in;
    logic                   sign_in;
    exp_t                   exp_in;

    logic                   out_valid;
    logic                   out_ready;
    logic [SIG_WIDTH:0]     sig_out;
    logic                   guard_out;
    logic                   round_out;
    logic                   sticky_out;
    logic                   sign_out;
    exp_t                   exp_out;
    logic                   zero_out;
    logic                   uflow_out;

    modport master (
        output in_valid, sum_in, cout_in, eff_op_in, sticky_in, sign_in, exp_in, out_ready,
        input  in_ready, out_valid, sig_out, guard_out, round_out, sticky_out, sign_out,
               exp_out, zero_out, uflow_out
    );

    modport slave (
        input  in_valid, sum_in, cout_in, eff_op_in, sticky_in, sign_in, exp_in, out_ready,
        output in_ready, out_valid, sig_out, guard_out, round_out, sticky_out, sign_out,
               exp_out, zero_out, uflow_out
    );

endinterface

// File: rtl/fma_lzc.sv
// Combinational leading-zero counter.
// data  : input vector, MSB first
// count : number of leading zeros; WIDTH when data is all zero
module fma_lzc #(
    parameter int unsigned WIDTH     = 51,
    parameter int unsigned CNT_WIDTH = 6
) (
    input  logic [WIDTH-1:0]     data,
    output logic [CNT_WIDTH-1:0] count
);

    // Scan upward; the highest set bit is the last one to write the count.
    always_comb begin
        count = CNT_WIDTH'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) count = CNT_WIDTH'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fma_norm_stage.sv
// Two-stage normalizer behind the FMA end-around-carry adder.
// S1 recovers sign/magnitude from sum, carry-out and effective op and counts leading
// zeros; S2 left-normalizes, adjusts the exponent and forms guard/round/sticky.
// clk, rst : clock and asynchronous active-high reset
// bus      : fma_norm_stage_if.slave (in_* valid/ready input, out_* valid/ready result)
// Build option FMA_NORM_DENORM_EN: clamp the shift so the exponent stops at 0 and emit
// subnormals; otherwise the full leading-zero count is applied and exp may go negative.
module fma_norm_stage
    import fma_pkg::*;
(
    input logic             clk,
    input logic             rst,
    fma_norm_stage_if.slave bus
);

    logic s1_valid_q, s2_valid_q;
    logic s1_adv, s2_adv;
    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;

    assign s2_adv       = ~s2_valid_q | bus.out_ready;
    assign s1_adv       = ~s1_valid_q | s2_adv;
    assign bus.in_ready = s1_adv;

    // Stage 1: magnitude recovery.
    logic [MAG_WIDTH-1:0] mag;
    logic                 mag_sign;
    logic [LZC_WIDTH-1:0] mag_lzc;

    always_comb begin
        mag      = {1'b0, bus.sum_in};
        mag_sign = bus.sign_in;
        if (!bus.eff_op_in) begin
            mag = {bus.cout_in, bus.sum_in};
        end else if (!bus.cout_in) begin
            // No end-around carry: result is negative, magnitude is the complement.
            mag      = {1'b0, ~bus.sum_in};
            mag_sign = ~bus.sign_in;
        end
    end

    fma_lzc #(
        .WIDTH    (MAG_WIDTH),
        .CNT_WIDTH(LZC_WIDTH)
    ) u_lzc (
        .data (mag),
        .count(mag_lzc)
    );

    always_comb begin
        s1_d.mag     = mag;
        s1_d.lzc     = mag_lzc;
        s1_d.sticky  = bus.sticky_in;
        s1_d.zero    = ~|mag;
        s1_d.sign    = s1_d.zero ? 1'b0 : mag_sign;
        // exp_in refers to sum bit ADDER_WIDTH-1; the magnitude MSB sits one above it.
        s1_d.exp_ref = s1_d.zero ? exp_t'(0) : bus.exp_in + exp_t'(1);
    end

    // Stage 2: normalize.
    logic [LZC_WIDTH-1:0] shift;
    logic [MAG_WIDTH-1:0] mag_norm;
    exp_t                 exp_ref;
    exp_t                 exp_norm;

    always_comb begin
        exp_ref = s1_q.exp_ref;
        shift   = s1_q.lzc;
`ifdef FMA_NORM_DENORM_EN
        if (exp_ref <= exp_t'(0)) begin
            shift = '0;
        end else if (exp_t'(s1_q.lzc) > exp_ref) begin
            shift = LZC_WIDTH'(exp_ref);
        end
`endif
        mag_norm = s1_q.mag << shift;
        exp_norm = s1_q.zero ? exp_t'(0) : exp_ref - exp_t'(shift);

        s2_d.sig    = mag_norm[MAG_WIDTH-1 -: SIG_WIDTH+1];
        s2_d.guard  = mag_norm[REST_WIDTH+1];
        s2_d.round  = mag_norm[REST_WIDTH];
        s2_d.sticky = (|mag_norm[REST_WIDTH-1:0]) | s1_q.sticky;
        s2_d.sign   = s1_q.sign;
        s2_d.expo   = exp_norm;
        s2_d.zero   = s1_q.zero;
        s2_d.uflow  = ~s1_q.zero & (exp_norm <= exp_t'(0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
        end else begin
            if (s1_adv) s1_valid_q <= bus.in_valid;
            if (bus.in_valid && s1_adv) s1_q <= s1_d;
            if (s2_adv) s2_valid_q <= s1_valid_q;
            if (s1_valid_q && s2_adv) s2_q <= s2_d;
        end
    end

    assign bus.out_valid  = s2_valid_q;
    assign bus.sig_out    = s2_q.sig;
    assign bus.guard_out  = s2_q.guard;
    assign bus.round_out  = s2_q.round;
    assign bus.sticky_out = s2_q.sticky;
    assign bus.sign_out   = s2_q.sign;
    assign bus.exp_out    = s2_q.expo;
    assign bus.zero_out   = s2_q.zero;
    assign bus.uflow_out  = s2_q.uflow;

endmodule

// File: tb/tb_fma_norm_stage.sv
// Self-checking bench for fma_norm_stage: directed cases, backpressure, randomized
// traffic against a reference model, and reset with both stages full.
module tb_fma_norm_stage;
    import fma_pkg::*;

    typedef struct packed {
        logic [49:0]        sum;
        logic               cout;
        logic               eff;
        logic               sticky;
        logic               sign;
        logic signed [9:0]  exp_in;
    } op_t;

    typedef struct packed {
        logic [23:0]        sig;
        logic               g;
        logic               r;
        logic               st;
        logic               sign;
        logic signed [9:0]  expo;
        logic               zero;
        logic               uflow;
    } res_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    fma_norm_stage_if bus ();

    fma_norm_stage dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required finish before 400us");
        $fatal(1);
    end

    // Reference: locate the leading one of the true magnitude and take a 24-bit window.
    function automatic res_t model(input op_t op);
        res_t         r;
        logic [50:0]  m;
        logic [127:0] w;
        int           p;
        int           e;
        int           ei;
        r  = '0;
        ei = int'($signed(op.exp_in));
        if (!op.eff)      m = {op.cout, op.sum};
        else if (op.cout) m = {1'b0, op.sum};
        else              m = {1'b0, ~op.sum};
        r.sign = (op.eff && !op.cout) ? ~op.sign : op.sign;
        if (m == '0) begin
            r.sign = 1'b0;
            r.zero = 1'b1;
            r.st   = op.sticky;
            return r;
        end
        p = 0;
        for (int i = 0; i < 51; i++) if (m[i]) p = i;
        e = ei + p - 49;
        w = {77'b0, m} << (127 - p);
`ifdef FMA_NORM_DENORM_EN
        if (e < 0) begin
            int sh;
            sh = (ei + 1 > 0) ? ei + 1 : 0;
            w  = {77'b0, m} << (77 + sh);
            e  = ei + 1 - sh;
        end
`endif
        r.sig   = w[127:104];
        r.g     = w[103];
        r.r     = w[102];
        r.st    = (|w[101:0]) | op.sticky;
        r.expo  = e[9:0];
        r.uflow = (e <= 0);
        return r;
    endfunction

    function automatic op_t rand_op();
        op_t        o;
        logic [49:0] r;
        int          k;
        int          v;
        r        = 50'({$urandom, $urandom});
        o.sum    = r >> $urandom_range(0, 49);
        k        = int'($urandom_range(0, 15));
        if (k == 0) o.sum = '0;
        else if (k == 1) o.sum = '1;
        o.cout   = 1'($urandom_range(0, 1));
        o.eff    = 1'($urandom_range(0, 1));
        o.sticky = 1'($urandom_range(0, 1));
        o.sign   = 1'($urandom_range(0, 1));
        v        = int'($urandom_range(0, 500)) - 100;
        o.exp_in = v[9:0];
        return o;
    endfunction

    function automatic res_t sample();
        res_t r;
        r.sig   = bus.sig_out;
        r.g     = bus.guard_out;
        r.r     = bus.round_out;
        r.st    = bus.sticky_out;
        r.sign  = bus.sign_out;
        r.expo  = bus.exp_out;
        r.zero  = bus.zero_out;
        r.uflow = bus.uflow_out;
        return r;
    endfunction

    task automatic drive(input op_t op, input logic valid);
        bus.in_valid  = valid;
        bus.sum_in    = op.sum;
        bus.cout_in   = op.cout;
        bus.eff_op_in = op.eff;
        bus.sticky_in = op.sticky;
        bus.sign_in   = op.sign;
        bus.exp_in    = op.exp_in;
    endtask

    // Send one op into an empty pipe, wait for its result, then let it drain.
    task automatic issue_and_wait(input op_t op, output res_t got, output bit ok,
                                  output int lat);
        ok  = 1'b0;
        lat = 0;
        got = '0;
        drive(op, 1'b1);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (!ok) begin
                @(posedge clk); #1;
                if (bus.out_valid) begin
                    ok  = 1'b1;
                    lat = i + 1;
                    got = sample();
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        drive('0, 1'b0);
        @(posedge clk); #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold_valid: out_valid=%b required 0", bus.out_valid);
        end
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: out_valid=%b required 0", bus.out_valid);
        end
        n_cmp++;
        if (sample() !== res_t'(0)) begin
            n_fail++;
            $display("FAIL reset_data: outputs=%h required 0", sample());
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: in_ready=%b required 1", bus.in_ready);
        end
    endtask

    task automatic test_add_overflow();
        op_t op; res_t got; bit ok; int lat;
        op = '0; op.cout = 1'b1; op.sign = 1'b1; op.exp_in = 10'sd130;
        issue_and_wait(op, got, ok, lat);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL add_ovf_timeout: no out_valid, required within 10 cycles");
        end else begin
            n_cmp++;
            if (lat !== 2) begin
                n_fail++; $display("FAIL add_ovf_latency: got %0d cycles required 2", lat);
            end
            n_cmp++;
            if (got.sig !== 24'h800000 || got.expo !== 10'd131) begin
                n_fail++;
                $display("FAIL add_ovf_sig_exp: sig=%h exp=%0d required 800000/131",
                         got.sig, $signed(got.expo));
            end
            n_cmp++;
            if ({got.g, got.r, got.st, got.sign, got.zero, got.uflow} !== 6'b000100) begin
                n_fail++;
                $display("FAIL add_ovf_flags: grs_sign_zero_uflow=%b required 000100",
                         {got.g, got.r, got.st, got.sign, got.zero, got.uflow});
            end
        end
    endtask

    task automatic test_neg_sub();
        op_t op; res_t got; bit ok; int lat;
        logic [49:0] one;
        one = 50'd1;
        op = '0; op.eff = 1'b1; op.sum = ~(one << 26); op.exp_in = 10'sd130;
        issue_and_wait(op, got, ok, lat);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL neg_sub_timeout: no out_valid, required within 10 cycles");
        end else begin
            n_cmp++;
            if (got.sig !== 24'h800000 || got.expo !== 10'd107) begin
                n_fail++;
                $display("FAIL neg_sub_sig_exp: sig=%h exp=%0d required 800000/107",
                         got.sig, $signed(got.expo));
            end
            n_cmp++;
            if ({got.g, got.r, got.st, got.sign, got.zero, got.uflow} !== 6'b000100) begin
                n_fail++;
                $display("FAIL neg_sub_flags: grs_sign_zero_uflow=%b required 000100",
                         {got.g, got.r, got.st, got.sign, got.zero, got.uflow});
            end
        end
    endtask

    task automatic test_cancel();
        op_t op; res_t got; bit ok; int lat;
        op = '0; op.eff = 1'b1; op.cout = 1'b1; op.sign = 1'b1; op.exp_in = 10'sd77;
        issue_and_wait(op, got, ok, lat);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL cancel_timeout: no out_valid, required within 10 cycles");
        end else begin
            n_cmp++;
            if (got.expo !== 10'd0 || got.sig !== 24'h0) begin
                n_fail++;
                $display("FAIL cancel_sig_exp: sig=%h exp=%0d required 0/0",
                         got.sig, $signed(got.expo));
            end
            n_cmp++;
            if ({got.sign, got.zero, got.uflow} !== 3'b010) begin
                n_fail++;
                $display("FAIL cancel_flags: sign_zero_uflow=%b required 010",
                         {got.sign, got.zero, got.uflow});
            end
        end
    endtask

    task automatic test_sticky_merge();
        op_t op; res_t got; bit ok; int lat;
        op = '0; op.sum = 50'h2_0000_0000_0005; op.sticky = 1'b1; op.exp_in = 10'sd100;
        issue_and_wait(op, got, ok, lat);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL sticky_timeout: no out_valid, required within 10 cycles");
        end else begin
            n_cmp++;
            if (got.sig !== 24'h800000 || got.expo !== 10'd100) begin
                n_fail++;
                $display("FAIL sticky_sig_exp: sig=%h exp=%0d required 800000/100",
                         got.sig, $signed(got.expo));
            end
            n_cmp++;
            if ({got.g, got.r, got.st} !== 3'b001) begin
                n_fail++;
                $display("FAIL sticky_grs: grs=%b required 001", {got.g, got.r, got.st});
            end
        end
    endtask

    task automatic test_denorm();
        op_t op; res_t got; bit ok; int lat;
        logic [49:0] one;
        logic [23:0] want_sig;
        logic [9:0]  want_exp;
        one = 50'd1;
        op = '0; op.sum = one << 40; op.exp_in = 10'sd5;
`ifdef FMA_NORM_DENORM_EN
        want_sig = 24'h080000;
        want_exp = 10'd0;
`else
        want_sig = 24'h800000;
        want_exp = 10'h3fc;  // -4
`endif
        issue_and_wait(op, got, ok, lat);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL denorm_timeout: no out_valid, required within 10 cycles");
        end else begin
            n_cmp++;
            if (got.sig !== want_sig || got.expo !== want_exp) begin
                n_fail++;
                $display("FAIL denorm_sig_exp: sig=%h exp=%0d required %h/%0d",
                         got.sig, $signed(got.expo), want_sig, $signed(want_exp));
            end
            n_cmp++;
            if ({got.zero, got.uflow} !== 2'b01) begin
                n_fail++;
                $display("FAIL denorm_flags: zero_uflow=%b required 01",
                         {got.zero, got.uflow});
            end
        end
    endtask

    task automatic test_backpressure();
        op_t  ops[4];
        res_t want[4];
        res_t snap, got;
        int   sent, recv;
        bit   have_snap;
        sent = 0; recv = 0; have_snap = 1'b0; snap = '0;
        for (int i = 0; i < 4; i++) begin
            ops[i]  = rand_op();
            want[i] = model(ops[i]);
        end
        for (int cyc = 0; cyc < 30 && recv < 4; cyc++) begin
            if (sent < 4) drive(ops[sent], 1'b1);
            else bus.in_valid = 1'b0;
            bus.out_ready = (cyc >= 5);
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                n_cmp++;
                if (bus.in_ready !== 1'b0 || sent !== 2) begin
                    n_fail++;
                    $display("FAIL bp_in_ready: in_ready=%b accepted=%0d required 0/2",
                             bus.in_ready, sent);
                end
                if (!have_snap) begin
                    snap      = sample();
                    have_snap = 1'b1;
                end else begin
                    n_cmp++;
                    if (bus.out_valid !== 1'b1 || sample() !== snap) begin
                        n_fail++;
                        $display("FAIL bp_hold: valid=%b out=%h required 1/%h",
                                 bus.out_valid, sample(), snap);
                    end
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                got = sample();
                n_cmp++;
                if (got !== want[recv]) begin
                    n_fail++;
                    $display("FAIL bp_result%0d: got %h required %h", recv, got, want[recv]);
                end
                recv++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (recv !== 4) begin
            n_fail++;
            $display("FAIL bp_count: received %0d results required 4", recv);
        end
    endtask

    task automatic test_random();
        res_t q[$];
        res_t want, got, snap;
        op_t  cur;
        bit   stalled;
        int   drained;
        stalled = 1'b0; snap = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            cur = rand_op();
            drive(cur, 1'($urandom_range(0, 3) != 0));
            bus.out_ready = 1'($urandom_range(0, 3) != 0);
            #1;
            if (stalled) begin
                n_cmp++;
                if (bus.out_valid !== 1'b1 || sample() !== snap) begin
                    n_fail++;
                    $display("FAIL rnd_hold: valid=%b out=%h required 1/%h",
                             bus.out_valid, sample(), snap);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_extra: result %h with nothing outstanding", sample());
                end else begin
                    want = q.pop_front();
                    got  = sample();
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL rnd_result: got %h required %h", got, want);
                    end
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            if (stalled) snap = sample();
            if (bus.in_valid && bus.in_ready) q.push_back(model(cur));
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drained = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (bus.out_valid) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_drain_extra: result %h with nothing outstanding",
                             sample());
                end else begin
                    want = q.pop_front();
                    if (sample() !== want) begin
                        n_fail++;
                        $display("FAIL rnd_drain: got %h required %h", sample(), want);
                    end
                end
                drained++;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL rnd_lost: %0d results outstanding required 0", q.size());
        end
    endtask

    task automatic test_reset_midflight();
        int seen;
        bus.out_ready = 1'b0;
        drive(rand_op(), 1'b1);
        @(posedge clk); #1;
        drive(rand_op(), 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_fill: valid=%b in_ready=%b required 1/0",
                     bus.out_valid, bus.in_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_valid: out_valid=%b required 0", bus.out_valid);
        end
        n_cmp++;
        if (sample() !== res_t'(0)) begin
            n_fail++;
            $display("FAIL mid_async_data: outputs=%h required 0", sample());
        end
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL mid_stale: %0d stale results after reset required 0", seen);
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_in_ready: in_ready=%b required 1", bus.in_ready);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_add_overflow();
        test_neg_sub();
        test_cancel();
        test_sticky_merge();
        test_denorm();
        test_backpressure();
        test_random();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
